dma_word_copy: RTL and testbench
================================

Name: dma_word_copy

Overview:
- Bus initiator for the peripheral memory request/response interface: copies a block of words from a source address range to a destination address range.
- It issues one request at a time: a read, then a write, per word.
- Sits beside the core on the peripheral request bus and drives the same addr/wr_data/wr_en/count request fields that memory-mapped peripherals (timer, register banks) consume.
- Consumes their rd_data/code responses.

Parameters:
- LEN_W, 16, width of the word-count command input.
- TIMEOUT, 255, cycles a request is held without a READY/INVALID code before it aborts with a timeout error; range 1..2^16-1.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_start  input  1  one-cycle command strobe; accepted only when o_busy=0
- i_src_addr  input  `ADDR_W  source byte address; must be word aligned
- i_dst_addr  input  `ADDR_W  destination byte address; must be word aligned
- i_len  input  LEN_W  number of words to copy
- o_busy  output  1  high from the cycle after an accepted start until DONE/ERR exits
- o_done  output  1  one-cycle pulse on successful completion
- o_error  output  1  sticky error flag; cleared by the next accepted start
- o_err_cause  output  2  0 none, 1 misaligned, 2 invalid response, 3 timeout
- o_err_addr  output  `ADDR_W  address of the failing request
- o_req_addr  output  `ADDR_W  request byte address
- o_req_wr_data  output  `WORD_W  write data
- o_req_wr_en  output  1  1 = write, 0 = read
- o_req_count  output  `MEM_COUNT_W  bytes requested; 0 = no request, `MEM_COUNT_WORD during RD/WR
- i_res_rd_data  input  `WORD_W  read data, valid when i_res_code==`MEM_CODE_READY
- i_res_code  input  `MEM_CODE_W  response code, combinational relative to the request

Behaviour:
- Reset: state IDLE.
  - o_busy, o_done, o_error, o_req_wr_en = 0.
  - o_req_count, o_req_addr, o_req_wr_data, o_err_addr, o_err_cause = 0.
  - Reset mid-transfer abandons the transfer; the request is dropped in the same cycle the reset is sampled.
- States: IDLE, RD, WR, DONE, ERR.
- IDLE, i_start=1:
  - Latch src, dst and len; clear o_error and o_err_cause.
  - If (src|dst)[1:0]!=0: go to ERR, cause 1, err_addr = first misaligned address (src checked first).
  - Else if len==0: go to DONE (no bus traffic).
  - Else: go to RD.
- i_start while o_busy=1 is ignored.
- RD:
  - Drive o_req_addr=src, wr_en=0, count=`MEM_COUNT_WORD.
  - Code READY: capture rd_data into the data register; go to WR next cycle.
  - Code STALL: hold the request unchanged.
  - Any other code, including X/Z from an unmapped address: go to ERR, cause 2.
- WR:
  - Drive o_req_addr=dst, wr_en=1, wr_data=data register, count=`MEM_COUNT_WORD.
  - Code READY: src+=4, dst+=4, remaining-=1. If remaining was 1, go to DONE; else go to RD.
  - STALL and other codes are handled as in RD.
- Minimum throughput is 2 cycles per word with zero-wait responders.
- Timeout:
  - A per-phase counter resets on entry to RD or WR and increments each STALL cycle.
  - When it reaches TIMEOUT: go to ERR, cause 3, err_addr = current request address.
- DONE: o_done=1 for exactly one cycle, o_busy=0, then IDLE.
- ERR: one cycle, o_busy=0, then IDLE. o_error stays high.
- Addresses wrap modulo 2^`ADDR_W with no error. Overlapping ranges are copied in ascending order with no overlap detection.
- o_req_* are registered; o_req_count=0 in IDLE, DONE and ERR.

Decomposition:
- mem_codes.vh: `MEM_CODE_READY, `MEM_CODE_STALL, `MEM_CODE_INVALID, `MEM_COUNT_WORD, and the new localparams for the error-cause encodings.
- config.vh: `ADDR_W, `WORD_W, `MEM_COUNT_W.
- One sub-module, mem_req_timeout, a loadable stall counter with a terminal flag. Everything else stays in the top FSM.

Test Plan:
- src=0x100, dst=0x200, len=3, zero-wait memory model -> reads 0x100, 0x104, 0x108 and writes 0x200, 0x204, 0x208 in alternation.
  - Data is copied exactly.
  - o_done pulses exactly 6 cycles after the first RD cycle.
  - o_busy falls with done.
- Same copy with the responder inserting 2 STALL cycles on every request -> request fields hold stable during stalls; the copy completes correctly with no error.
- len=0 -> no request is issued; o_done pulses 2 cycles after i_start.
- src=0x102 -> no request is issued; o_error=1, cause=1, err_addr=0x102.
- dst hits an unmapped address returning Z on the 2nd write -> ERR with cause 2 and err_addr=dst+4. The first word is written; the second is not.
- TIMEOUT=4, responder returns STALL forever -> ERR after 4 stall cycles with cause 3.
  - Then reset asserted mid-copy in a second run -> all outputs are 0 the next cycle and a new start works.

Source files
------------

// File: rtl/dma_word_copy_pkg.sv
// Shared definitions for the word-copy DMA initiator.
// Bus widths, peripheral response codes, the request size for one word,
// the error-cause encodings reported on o_err_cause and the FSM state type.
package dma_word_copy_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 3;
  localparam int MEM_CODE_W  = 2;

  // Bytes moved by one request; the copy engine only ever moves whole words.
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

  // Response codes. Code 0 is deliberately unassigned so that an undriven
  // response bus never reads as READY or STALL.
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READY   = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_STALL   = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_MISALIGNED = 2'd1,
    ERR_INVALID    = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } err_cause_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dma_word_copy_timeout.sv
// mem_req_timeout: stall counter for one bus request phase.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clr        : return the count to zero (any cycle that is not a stall)
//   inc        : count one stall cycle
//   expire     : the stall being counted this cycle is number TIMEOUT
module mem_req_timeout #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Flag the stall that would bring the count to TIMEOUT, so the FSM leaves
  // on exactly that cycle and the counter never has to hold TIMEOUT itself.
  assign expire = inc && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/dma_word_copy.sv
// dma_word_copy: copies i_len words from i_src_addr to i_dst_addr over the
// peripheral request/response bus, one read then one write per word.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   i_start             : command strobe, accepted only while o_busy=0
//   i_src_addr/dst/len  : command; addresses must be word aligned
//   o_busy, o_done      : transfer in progress / one-cycle completion pulse
//   o_error, o_err_*    : sticky error flag, cause code and failing address
//   o_req_*             : registered request fields (count=0 means idle)
//   i_res_rd_data/code  : combinational response to the current request
module dma_word_copy
  import dma_word_copy_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_src_addr,
  input  logic [ADDR_W-1:0]      i_dst_addr,
  input  logic [LEN_W-1:0]       i_len,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_error,
  output logic [1:0]             o_err_cause,
  output logic [ADDR_W-1:0]      o_err_addr,
  output logic [ADDR_W-1:0]      o_req_addr,
  output logic [WORD_W-1:0]      o_req_wr_data,
  output logic                   o_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_req_count,
  input  logic [WORD_W-1:0]      i_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_res_code
);

  state_t            state_reg;
  logic              pending_reg;
  logic [ADDR_W-1:0] src_reg;
  logic [ADDR_W-1:0] dst_reg;
  logic [LEN_W-1:0]  remain_reg;

  logic       in_phase;
  logic       code_ready;
  logic       code_stall;
  logic       stall_inc;
  logic       stall_clr;
  logic       tmo_expire;
  logic       phase_fail;
  err_cause_t phase_cause;

  assign in_phase   = (state_reg == ST_RD) || (state_reg == ST_WR);
  // Equality against X/Z is not true, so undriven codes fall into the error path.
  assign code_ready = (i_res_code == MEM_CODE_READY);
  assign code_stall = (i_res_code == MEM_CODE_STALL);
  assign stall_inc  = in_phase && code_stall;
  // Any non-stall cycle ends the phase, so clearing then also covers phase entry.
  assign stall_clr  = !stall_inc;

  mem_req_timeout #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (16)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (stall_clr),
    .inc    (stall_inc),
    .expire (tmo_expire)
  );

  always_comb begin
    phase_fail  = 1'b0;
    phase_cause = ERR_INVALID;
    if (in_phase && !code_ready) begin
      if (!code_stall) begin
        phase_fail = 1'b1;
      end else if (tmo_expire) begin
        phase_fail  = 1'b1;
        phase_cause = ERR_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pending_reg   <= 1'b0;
      src_reg       <= '0;
      dst_reg       <= '0;
      remain_reg    <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_err_cause   <= ERR_NONE;
      o_err_addr    <= '0;
      o_req_addr    <= '0;
      o_req_wr_data <= '0;
      o_req_wr_en   <= 1'b0;
      o_req_count   <= '0;
    end else begin
      o_done <= 1'b0;
      if (phase_fail) begin
        state_reg   <= ST_ERR;
        o_busy      <= 1'b0;
        o_error     <= 1'b1;
        o_err_cause <= phase_cause;
        o_err_addr  <= o_req_addr;
        o_req_count <= '0;
        o_req_wr_en <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (pending_reg) begin
              // The command was registered last cycle; decode it from the
              // registers rather than straight off the input pins.
              pending_reg <= 1'b0;
              if (!is_word_aligned(src_reg)) begin
                state_reg   <= ST_ERR;
                o_busy      <= 1'b0;
                o_error     <= 1'b1;
                o_err_cause <= ERR_MISALIGNED;
                o_err_addr  <= src_reg;
              end else if (!is_word_aligned(dst_reg)) begin
                state_reg   <= ST_ERR;
                o_busy      <= 1'b0;
                o_error     <= 1'b1;
                o_err_cause <= ERR_MISALIGNED;
                o_err_addr  <= dst_reg;
              end else if (remain_reg == '0) begin
                state_reg <= ST_DONE;
                o_busy    <= 1'b0;
                o_done    <= 1'b1;
              end else begin
                state_reg   <= ST_RD;
                o_req_addr  <= src_reg;
                o_req_wr_en <= 1'b0;
                o_req_count <= MEM_COUNT_WORD;
              end
            end else if (i_start) begin
              pending_reg <= 1'b1;
              src_reg     <= i_src_addr;
              dst_reg     <= i_dst_addr;
              remain_reg  <= i_len;
              o_busy      <= 1'b1;
              o_error     <= 1'b0;
              o_err_cause <= ERR_NONE;
            end
          end

          ST_RD: begin
            // o_req_wr_data doubles as the data register between read and write.
            if (code_ready) begin
              state_reg     <= ST_WR;
              o_req_addr    <= dst_reg;
              o_req_wr_en   <= 1'b1;
              o_req_wr_data <= i_res_rd_data;
            end
          end

          ST_WR: begin
            if (code_ready) begin
              src_reg    <= src_reg + ADDR_W'(4);
              dst_reg    <= dst_reg + ADDR_W'(4);
              remain_reg <= remain_reg - LEN_W'(1);
              if (remain_reg == LEN_W'(1)) begin
                state_reg   <= ST_DONE;
                o_busy      <= 1'b0;
                o_done      <= 1'b1;
                o_req_count <= '0;
                o_req_wr_en <= 1'b0;
              end else begin
                state_reg   <= ST_RD;
                o_req_addr  <= src_reg + ADDR_W'(4);
                o_req_wr_en <= 1'b0;
              end
            end
          end

          ST_DONE: state_reg <= ST_IDLE;
          ST_ERR:  state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_word_copy.sv
// Testbench for dma_word_copy: a peripheral responder with a word memory,
// configurable stalls and one invalid region, plus a reference copy model
// that predicts the bus transaction sequence and final memory contents.
module tb_dma_word_copy;
  import dma_word_copy_pkg::*;

  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   i_start;
  logic [ADDR_W-1:0]      i_src_addr;
  logic [ADDR_W-1:0]      i_dst_addr;
  logic [LEN_W-1:0]       i_len;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_error;
  logic [1:0]             o_err_cause;
  logic [ADDR_W-1:0]      o_err_addr;
  logic [ADDR_W-1:0]      o_req_addr;
  logic [WORD_W-1:0]      o_req_wr_data;
  logic                   o_req_wr_en;
  logic [MEM_COUNT_W-1:0] o_req_count;
  logic [WORD_W-1:0]      i_res_rd_data;
  logic [MEM_CODE_W-1:0]  i_res_code;

  dma_word_copy #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_src_addr    (i_src_addr),
    .i_dst_addr    (i_dst_addr),
    .i_len         (i_len),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error),
    .o_err_cause   (o_err_cause),
    .o_err_addr    (o_err_addr),
    .o_req_addr    (o_req_addr),
    .o_req_wr_data (o_req_wr_data),
    .o_req_wr_en   (o_req_wr_en),
    .o_req_count   (o_req_count),
    .i_res_rd_data (i_res_rd_data),
    .i_res_code    (i_res_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory and responder ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } xact_t;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  xact_t       bus_log [$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  int          stall_mode = 0;   // 0 fixed stall_n, 1 random 0..2, 2 stall forever
  int          stall_n = 0;
  int          stall_cnt = 0;
  int          stall_target = 0;
  bit          new_req = 1'b1;
  bit          prev_stalled = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  bit          unmapped_en = 1'b0;
  logic [31:0] unmapped_addr = '0;
  int          n_req_cycles = 0;

  // Outputs change on posedge; the response is set up on negedge so it is
  // stable, as a combinational decode would be, when the DUT samples it.
  always @(negedge clk) begin
    if (reset || o_req_count == '0) begin
      prev_stalled = 1'b0;
      stall_cnt    = 0;
      new_req      = 1'b1;
      i_res_code   = '0;
    end else begin
      n_req_cycles++;
      check_eq("req_count_word", 64'(o_req_count), 64'(MEM_COUNT_WORD));
      if (prev_stalled) begin
        check_eq("stall_hold_addr", 64'(o_req_addr), 64'(prev_addr));
        check_eq("stall_hold_we", 64'(o_req_wr_en), 64'(prev_we));
        if (o_req_wr_en) check_eq("stall_hold_data", 64'(o_req_wr_data), 64'(prev_wdata));
      end
      if (new_req) begin
        stall_target = (stall_mode == 1) ? int'($urandom_range(0, 2)) : stall_n;
        new_req = 1'b0;
      end
      prev_addr  = o_req_addr;
      prev_we    = o_req_wr_en;
      prev_wdata = o_req_wr_data;
      if (unmapped_en && o_req_addr == unmapped_addr) begin
        i_res_code   = MEM_CODE_INVALID;
        prev_stalled = 1'b0;
        stall_cnt    = 0;
        new_req      = 1'b1;
      end else if (stall_mode == 2 || stall_cnt < stall_target) begin
        i_res_code   = MEM_CODE_STALL;
        stall_cnt++;
        prev_stalled = 1'b1;
      end else begin
        i_res_code = MEM_CODE_READY;
        if (o_req_wr_en) begin
          mem[o_req_addr] = o_req_wr_data;
          bus_log.push_back('{o_req_addr, 1'b1, o_req_wr_data});
        end else begin
          i_res_rd_data = rd_word(o_req_addr);
          bus_log.push_back('{o_req_addr, 1'b0, i_res_rd_data});
        end
        stall_cnt    = 0;
        new_req      = 1'b1;
        prev_stalled = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                         output int start_cyc, output int first_rd, output int end_cyc,
                         output bit done_seen, output bit err_seen);
    bit prev_busy;
    i_src_addr = src;
    i_dst_addr = dst;
    i_len      = len;
    i_start    = 1'b1;
    start_cyc  = cyc;
    first_rd   = -1;
    end_cyc    = -1;
    done_seen  = 1'b0;
    err_seen   = 1'b0;
    prev_busy  = 1'b0;
    bus_log.delete();
    n_req_cycles = 0;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (first_rd < 0 && o_req_count != '0) first_rd = cyc;
      if (o_done || o_error) begin
        end_cyc   = cyc;
        done_seen = o_done;
        err_seen  = o_error;
        check_eq("busy_low_at_end", 64'(o_busy), 64'd0);
        check_eq("busy_high_before_end", 64'(prev_busy), 64'd1);
        break;
      end
      prev_busy = o_busy;
      @(negedge clk);
    end
    if (end_cyc < 0) check_eq("end_within_bound", 64'd0, 64'd1);
    @(negedge clk);
    check_eq("done_one_cycle", 64'(o_done), 64'd0);
  endtask

  // Predict the alternating read/write sequence from ref_mem (snapshot taken
  // before the copy), keep only the first nent accepted transactions, then
  // compare both the bus log and the destination words.
  task automatic verify_log(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int nent);
    xact_t exp_q[$];
    logic [31:0] a, d;
    for (int i = 0; i < len; i++) begin
      a = src + 32'(4 * i);
      d = ref_rd(a);
      exp_q.push_back('{a, 1'b0, d});
      exp_q.push_back('{dst + 32'(4 * i), 1'b1, d});
      if (exp_q.size() <= nent) ref_mem[dst + 32'(4 * i)] = d;
    end
    check_eq({tag, "_nxact"}, 64'(bus_log.size()), 64'(nent));
    for (int i = 0; i < nent && i < bus_log.size(); i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), 64'(bus_log[i].addr), 64'(exp_q[i].addr));
      check_eq($sformatf("%s_we%0d", tag, i), 64'(bus_log[i].we), 64'(exp_q[i].we));
      check_eq($sformatf("%s_data%0d", tag, i), 64'(bus_log[i].data), 64'(exp_q[i].data));
    end
    for (int i = 0; i < len; i++) begin
      a = dst + 32'(4 * i);
      check_eq($sformatf("%s_mem%0d", tag, i), 64'(rd_word(a)), 64'(ref_rd(a)));
    end
    $display("copy %s src=%08h dst=%08h len=%0d xacts=%0d", tag, src, dst, len, bus_log.size());
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, 64'(o_busy), 64'd0);
    check_eq({tag, "_done"}, 64'(o_done), 64'd0);
    check_eq({tag, "_error"}, 64'(o_error), 64'd0);
    check_eq({tag, "_cause"}, 64'(o_err_cause), 64'd0);
    check_eq({tag, "_err_addr"}, 64'(o_err_addr), 64'd0);
    check_eq({tag, "_req_addr"}, 64'(o_req_addr), 64'd0);
    check_eq({tag, "_req_data"}, 64'(o_req_wr_data), 64'd0);
    check_eq({tag, "_req_we"}, 64'(o_req_wr_en), 64'd0);
    check_eq({tag, "_req_count"}, 64'(o_req_count), 64'd0);
  endtask

  // Success: done pulse, no error, predicted traffic and memory.
  task automatic copy_ok(input string tag, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len);
    int sc, fr, ec;
    bit ds, es;
    ref_mem = mem;
    do_copy(src, dst, len, sc, fr, ec, ds, es);
    check_eq({tag, "_done"}, 64'(ds), 64'd1);
    check_eq({tag, "_no_error"}, 64'(es), 64'd0);
    verify_log(tag, src, dst, int'(len), 2 * int'(len));
  endtask

  task automatic copy_misaligned(input string tag, input logic [31:0] src, input logic [31:0] dst,
                                 input logic [31:0] exp_addr);
    int sc, fr, ec;
    bit ds, es;
    do_copy(src, dst, 16'd3, sc, fr, ec, ds, es);
    check_eq({tag, "_error"}, 64'(es), 64'd1);
    check_eq({tag, "_cause"}, 64'(o_err_cause), 64'(ERR_MISALIGNED));
    check_eq({tag, "_err_addr"}, 64'(o_err_addr), 64'(exp_addr));
    check_eq({tag, "_no_req"}, 64'(n_req_cycles), 64'd0);
    check_eq({tag, "_sticky"}, 64'(o_error), 64'd1);
    $display("misaligned %s src=%08h dst=%08h err_addr=%08h", tag, src, dst, o_err_addr);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int sc, fr, ec;
    bit ds, es;
    logic [31:0] rs, rdst;
    logic [15:0] rl;

    reset = 1'b1;
    i_start = 1'b0;
    i_src_addr = '0;
    i_dst_addr = '0;
    i_len = '0;
    i_res_rd_data = '0;
    i_res_code = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Zero-wait three-word copy with latency checks.
    ref_mem = mem;
    do_copy(32'h100, 32'h200, 16'd3, sc, fr, ec, ds, es);
    check_eq("basic_done", 64'(ds), 64'd1);
    check_eq("basic_no_error", 64'(es), 64'd0);
    check_eq("basic_done_latency", 64'(ec - fr), 64'd6);
    verify_log("basic", 32'h100, 32'h200, 3, 6);

    // Two stalls on every request.
    stall_mode = 0;
    stall_n = 2;
    copy_ok("stall2", 32'h100, 32'h200, 16'd3);
    stall_n = 0;

    // Zero length: no traffic, done two cycles after the start strobe.
    do_copy(32'h100, 32'h200, 16'd0, sc, fr, ec, ds, es);
    check_eq("len0_done", 64'(ds), 64'd1);
    check_eq("len0_latency", 64'(ec - sc), 64'd2);
    check_eq("len0_no_req", 64'(n_req_cycles), 64'd0);

    copy_misaligned("mis_src", 32'h102, 32'h200, 32'h102);
    copy_misaligned("mis_dst", 32'h100, 32'h203, 32'h203);
    copy_misaligned("mis_both", 32'h101, 32'h202, 32'h101);

    // Invalid response on the second write.
    unmapped_en = 1'b1;
    unmapped_addr = 32'h504;
    ref_mem = mem;
    do_copy(32'h100, 32'h500, 16'd3, sc, fr, ec, ds, es);
    check_eq("inval_error", 64'(es), 64'd1);
    check_eq("inval_cause", 64'(o_err_cause), 64'(ERR_INVALID));
    check_eq("inval_err_addr", 64'(o_err_addr), 64'h504);
    verify_log("inval", 32'h100, 32'h500, 3, 3);
    unmapped_en = 1'b0;

    // Endless stall: abort after TIMEOUT stall cycles.
    stall_mode = 2;
    do_copy(32'h300, 32'h400, 16'd2, sc, fr, ec, ds, es);
    check_eq("tmo_error", 64'(es), 64'd1);
    check_eq("tmo_cause", 64'(o_err_cause), 64'(ERR_TIMEOUT));
    check_eq("tmo_err_addr", 64'(o_err_addr), 64'h300);
    check_eq("tmo_latency", 64'(ec - fr), 64'(TIMEOUT));
    check_eq("tmo_stall_cycles", 64'(n_req_cycles), 64'(TIMEOUT));
    check_eq("tmo_no_xact", 64'(bus_log.size()), 64'd0);

    // Randomised copies with random stalls, overlapping ranges allowed.
    stall_mode = 1;
    for (int t = 0; t < 6; t++) begin
      rs   = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      rdst = 32'h1000 + 32'(4 * $urandom_range(0, 15));
      rl   = 16'($urandom_range(1, 6));
      copy_ok($sformatf("rand%0d", t), rs, rdst, rl);
    end

    // Source range wraps through address zero.
    copy_ok("wrap", 32'hFFFF_FFF8, 32'h0000_0080, 16'd4);

    // Reset in the middle of a long copy, then a fresh copy.
    stall_mode = 0;
    i_src_addr = 32'h2000;
    i_dst_addr = 32'h3000;
    i_len = 16'd8;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("midrst_was_busy", 64'(o_busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    reset = 1'b0;
    @(negedge clk);
    copy_ok("after_rst", 32'h2000, 32'h3000, 16'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
